stage3: RTL and testbench
=========================

# stage3

Execute (EX) stage of the five-stage pipeline, sitting between ID/EX and the memory stage. Selects operand B, computes single-cycle ALU results, and runs an iterative 32-cycle multiply/divide unit that stalls the upstream stages. Registers ALU result, store data, destination register, control fields and zero flag into the EX/MEM bank consumed by the memory stage.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- idexValid  in  1  ID/EX holds a real instruction
- idexRs1Data, idexRs2Data, idexImm  in  32  operands and immediate
- idexAluSrc  in  1  1: operand B = idexImm, 0: idexRs2Data
- idexAluOp  in  4  operation code (package constants)
- idexRd  in  5  destination register
- idexMemCtrl  in  3  {memRead, memWrite, branch}, forwarded
- idexWbCtrl  in  2  writeback control, forwarded
- flush  in  1  kill the instruction in EX (taken branch)
- stall  out  1  upstream holds ID/EX and earlier stages
- exmemMemWriteAddr  out  32  result / data-memory address
- exmemMemWriteData  out  32  store data (idexRs2Data)
- exmemRd  out  5; exmemMemCtrl  out  3; exmemWbCtrl  out  2
- exmemZero  out  1  result == 0

## Operation
- Ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7 (shift by B[4:0]), SLT 8, SLTU 9 (result 0/1), MUL 10 (low 32 of unsigned product), MULHU 11 (high 32), DIVU 12, REMU 13; 14–15 behave as ADD.
- Ops 0–9, 14, 15 are short: result registered at the next edge, stall=0.
- Ops 10–13 are long; FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE, valid long op: stall=1 combinationally; at edge load A, B, op, counter=31; -> BUSY.
  - BUSY: stall=1; one shift-add (MUL) or restoring-subtract (DIV) step per edge; counter decrements; at edge with counter==0 -> DONE.
  - DONE: stall=0; result muxed into EX/MEM at edge; -> IDLE.
- While stalled, EX/MEM receives a bubble: exmemMemCtrl=0, exmemWbCtrl=0, other fields don't-care but driven 0.
- Divide by zero: DIVU=32'hFFFFFFFF, REMU=dividend. Full 32 iterations still run.
- idexValid=0: bubble into EX/MEM, FSM stays IDLE.
- flush=1: EX/MEM gets a bubble at that edge; FSM forced to IDLE, iteration discarded; flush wins over DONE and short ops.
- exmemZero = (registered result == 0), computed for every op; branch resolution is done downstream.
- exmemMemWriteData always idexRs2Data regardless of idexAluSrc.

## Timing
- Reset (async): all exmem* outputs 0, FSM IDLE, counter 0, stall 0 once rst deasserted with no long op present.
- Short op: 1-cycle latency, no stall.
- Long op presented in cycle 0: stall high cycles 0–32 (33 cycles); result visible on EX/MEM after edge 33; upstream advances at that same edge.
- Back-to-back long ops: second presented in cycle 34, sees IDLE, starts new sequence; no overlap.
- rst mid-iteration: immediate abort to reset values; partial result lost.
- Upstream must hold all idex* inputs stable while stall=1; operands are latched at entry, but op/rd/ctrl are sampled in DONE.

## Structure
- Package riscie_pkg: ALU op constants, FSM state encoding (IDLE/BUSY/DONE), XLEN.
- Sub-module muldiv_iter: operand latch, 64-bit product/remainder register, 5-bit counter, start/done handshake; stage3 owns FSM sequencing, operand mux, short-op ALU and EX/MEM registers.

## Test plan
- ADD rs1=5, imm=-7, aluSrc=1 -> exmemMemWriteAddr=32'hFFFFFFFE, zero=0, after 1 edge, stall never high.
- SUB rs1=rs2=42, memCtrl=3'b001 -> result 0, exmemZero=1, exmemMemCtrl=3'b001.
- MULHU 32'hFFFFFFFF × 32'hFFFFFFFF -> stall high 33 cycles, bubbles on EX/MEM, then result 32'hFFFFFFFE; MUL same operands -> 32'h00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 32'hFFFFFFFF, REMU 123/0 -> 123.
- flush at BUSY cycle 10 of a DIVU -> bubble, stall drops next cycle, following ADD completes normally.
- rst asserted mid-MUL -> all outputs 0 immediately, FSM IDLE, next SLTU (-1 vs 1) yields 0.

Source files
------------

// File: rtl/riscie_pkg.sv
// Shared definitions for the execute stage: data width, ALU op codes and
// the state encoding of the iterative multiply/divide sequencer.
package riscie_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdState_e;

    function automatic logic isLongOp(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/stage3_muldiv_iter.sv
// Radix-2 iterative unit: unsigned shift-add multiply or restoring divide,
// one step per enabled edge, 32 steps per operation.
module muldiv_iter
    import riscie_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            abort,
    input  logic            isDiv,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic [XLEN-1:0] accHi,
    output logic [XLEN-1:0] accLo,
    output logic            done
);

    logic [XLEN-1:0] divisor;
    logic            divMode;
    logic [4:0]      count;
    logic [XLEN:0]   addSum;
    logic [XLEN:0]   shiftRem;
    logic [XLEN-1:0] subDiff;
    logic [XLEN-1:0] nextHi;
    logic [XLEN-1:0] nextLo;

    // accHi holds the partial product high half (MUL) or the running remainder
    // (DIV); accLo shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        addSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
        shiftRem = {accHi, accLo[XLEN-1]};
        subDiff  = shiftRem[XLEN-1:0] - divisor;
        nextHi   = addSum[XLEN:1];
        nextLo   = {addSum[0], accLo[XLEN-1:1]};
        if (divMode) begin
            if (shiftRem >= {1'b0, divisor}) begin
                nextHi = subDiff;
                nextLo = {accLo[XLEN-2:0], 1'b1};
            end else begin
                nextHi = shiftRem[XLEN-1:0];
                nextLo = {accLo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accHi   <= '0;
            accLo   <= '0;
            divisor <= '0;
            divMode <= 1'b0;
            count   <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            accHi   <= '0;
            accLo   <= opA;
            divisor <= opB;
            divMode <= isDiv;
            count   <= 5'd31;
        end else if (step) begin
            accHi <= nextHi;
            accLo <= nextLo;
            count <= count - 5'd1;
        end
    end

    assign done = (count == 5'd0);

endmodule

// File: rtl/stage3.sv
// Execute stage: operand-B select, single-cycle ALU, multi-cycle mul/div
// sequencing with upstream stall, and the EX/MEM register bank.
module stage3
    import riscie_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            idexValid,
    input  logic [XLEN-1:0] idexRs1Data,
    input  logic [XLEN-1:0] idexRs2Data,
    input  logic [XLEN-1:0] idexImm,
    input  logic            idexAluSrc,
    input  logic [3:0]      idexAluOp,
    input  logic [4:0]      idexRd,
    input  logic [2:0]      idexMemCtrl,
    input  logic [1:0]      idexWbCtrl,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] exmemMemWriteAddr,
    output logic [XLEN-1:0] exmemMemWriteData,
    output logic [4:0]      exmemRd,
    output logic [2:0]      exmemMemCtrl,
    output logic [1:0]      exmemWbCtrl,
    output logic            exmemZero,
    output logic [1:0]      dbgState
);

    mdState_e        state;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] mdHi;
    logic [XLEN-1:0] mdLo;
    logic [XLEN-1:0] result;
    logic            mdDone;
    logic            longOp;
    logic            startLong;
    logic            commit;

    assign opB       = idexAluSrc ? idexImm : idexRs2Data;
    assign longOp    = isLongOp(idexAluOp);
    assign startLong = (state == ST_IDLE) && idexValid && longOp && !flush;
    assign stall     = !rst && ((state == ST_BUSY) || ((state == ST_IDLE) && idexValid && longOp));
    assign commit    = !flush && (((state == ST_IDLE) && idexValid && !longOp) || (state == ST_DONE));
    // Odd long ops (MULHU, REMU) take the high half of the accumulator.
    assign result    = (state == ST_DONE) ? (idexAluOp[0] ? mdHi : mdLo) : aluResult;
    assign dbgState  = state;

    always_comb begin
        aluResult = idexRs1Data + opB;
        case (idexAluOp)
            OP_SUB:  aluResult = idexRs1Data - opB;
            OP_AND:  aluResult = idexRs1Data & opB;
            OP_OR:   aluResult = idexRs1Data | opB;
            OP_XOR:  aluResult = idexRs1Data ^ opB;
            OP_SLL:  aluResult = idexRs1Data << opB[4:0];
            OP_SRL:  aluResult = idexRs1Data >> opB[4:0];
            OP_SRA:  aluResult = $signed(idexRs1Data) >>> opB[4:0];
            OP_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(idexRs1Data) < $signed(opB)};
            OP_SLTU: aluResult = {{(XLEN-1){1'b0}}, idexRs1Data < opB};
            default: aluResult = idexRs1Data + opB;
        endcase
    end

    muldiv_iter u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (startLong),
        .step  ((state == ST_BUSY) && !flush),
        .abort (flush),
        .isDiv (idexAluOp[2]),
        .opA   (idexRs1Data),
        .opB   (opB),
        .accHi (mdHi),
        .accLo (mdLo),
        .done  (mdDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            exmemMemWriteAddr <= '0;
            exmemMemWriteData <= '0;
            exmemRd           <= '0;
            exmemMemCtrl      <= '0;
            exmemWbCtrl       <= '0;
            exmemZero         <= 1'b0;
        end else begin
            exmemMemWriteAddr <= commit ? result : '0;
            exmemMemWriteData <= commit ? idexRs2Data : '0;
            exmemRd           <= commit ? idexRd : '0;
            exmemMemCtrl      <= commit ? idexMemCtrl : '0;
            exmemWbCtrl       <= commit ? idexWbCtrl : '0;
            exmemZero         <= commit && (result == '0);
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (startLong) state <= ST_BUSY;
                    ST_BUSY: if (mdDone) state <= ST_DONE;
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stage3.sv
// Self-checking bench for the execute stage; a reference model feeds an
// expected queue that is drained whenever EX/MEM takes a real result.
module tb_stage3;
    import riscie_pkg::*;

    localparam int EW = 75;

    logic        clk = 1'b0;
    logic        rst;
    logic        idexValid;
    logic [31:0] idexRs1Data, idexRs2Data, idexImm;
    logic        idexAluSrc;
    logic [3:0]  idexAluOp;
    logic [4:0]  idexRd;
    logic [2:0]  idexMemCtrl;
    logic [1:0]  idexWbCtrl;
    logic        flush;
    logic        stall;
    logic [31:0] exmemMemWriteAddr, exmemMemWriteData;
    logic [4:0]  exmemRd;
    logic [2:0]  exmemMemCtrl;
    logic [1:0]  exmemWbCtrl;
    logic        exmemZero;
    logic [1:0]  dbgState;

    logic [EW-1:0] exp_q[$];
    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stage3 dut (
        .clk(clk), .rst(rst), .idexValid(idexValid),
        .idexRs1Data(idexRs1Data), .idexRs2Data(idexRs2Data), .idexImm(idexImm),
        .idexAluSrc(idexAluSrc), .idexAluOp(idexAluOp), .idexRd(idexRd),
        .idexMemCtrl(idexMemCtrl), .idexWbCtrl(idexWbCtrl), .flush(flush),
        .stall(stall), .exmemMemWriteAddr(exmemMemWriteAddr),
        .exmemMemWriteData(exmemMemWriteData), .exmemRd(exmemRd),
        .exmemMemCtrl(exmemMemCtrl), .exmemWbCtrl(exmemWbCtrl),
        .exmemZero(exmemZero), .dbgState(dbgState)
    );

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return {31'b0, $signed(a) < $signed(b)};
            4'd9:  return {31'b0, a < b};
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFFFFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [EW-1:0] pack(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [4:0] rd, input logic [2:0] mem,
                                           input logic [1:0] wb, input logic zero);
        return {addr, data, rd, mem, wb, zero};
    endfunction

    function automatic logic [EW-1:0] actual();
        return pack(exmemMemWriteAddr, exmemMemWriteData, exmemRd, exmemMemCtrl, exmemWbCtrl, exmemZero);
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic aluSrc,
                          input logic [4:0] rd, input logic [2:0] mem, input logic [1:0] wb);
        logic [31:0]   r;
        logic [EW-1:0] exp_v;
        logic [EW-1:0] got;
        logic          st;
        int            stallCnt;
        int            expStall;
        bit            done;
        idexValid = 1'b1; idexAluOp = op; idexRs1Data = a; idexRs2Data = b;
        idexImm = imm; idexAluSrc = aluSrc; idexRd = rd; idexMemCtrl = mem; idexWbCtrl = wb;
        r = model(op, a, aluSrc ? imm : b);
        exp_q.push_back(pack(r, b, rd, mem, wb, r == 32'd0));
        expStall = (op >= 4'd10 && op <= 4'd13) ? 33 : 0;
        stallCnt = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            st = stall;
            @(posedge clk); #1;
            if (st) begin
                stallCnt++;
                total++;
                got = actual();
                if (got !== '0) $display("FAIL %s bubble: got %h required 0", name, got);
                else passed++;
            end else begin
                exp_v = exp_q.pop_front();
                got = actual();
                total++;
                if (got !== exp_v) $display("FAIL %s result: got %h required %h", name, got, exp_v);
                else passed++;
                done = 1'b1;
            end
        end
        total++;
        if (!done) $display("FAIL %s timeout: no result within 100 cycles required one", name);
        else if (stallCnt !== expStall) $display("FAIL %s stall cycles: got %0d required %0d", name, stallCnt, expStall);
        else passed++;
        idexValid = 1'b0;
    endtask

    task automatic check_idle_bubble(input string name);
        total++;
        if (actual() !== '0 || dbgState !== 2'd0)
            $display("FAIL %s: got out=%h state=%0d required out=0 state=0", name, actual(), dbgState);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; idexValid = 1'b0; idexRs1Data = '0; idexRs2Data = '0;
        idexImm = '0; idexAluSrc = 1'b0; idexAluOp = '0; idexRd = '0; idexMemCtrl = '0; idexWbCtrl = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_bubble("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_bubble("reset_released");
        total++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall);
        else passed++;
    endtask

    task automatic test_short();
        logic [3:0]  op;
        logic [31:0] a, b;
        run_op("add_imm", 4'd0, 32'd5, 32'd99, 32'hFFFFFFF9, 1'b1, 5'd3, 3'b000, 2'b01);
        run_op("sub_zero", 4'd1, 32'd42, 32'd42, 32'd0, 1'b0, 5'd4, 3'b001, 2'b00);
        run_op("sra_neg", 4'd7, 32'h80000010, 32'd4, 32'd0, 1'b0, 5'd5, 3'b010, 2'b10);
        run_op("slt_neg", 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd6, 3'b100, 2'b11);
        run_op("op15_add", 4'd15, 32'd7, 32'd8, 32'd0, 1'b0, 5'd7, 3'b011, 2'b01);
        for (int i = 0; i < 10; i++) begin
            op = (i < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(14, 15));
            a = $urandom;
            b = $urandom;
            run_op("rand_short", op, a, b, $urandom, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_invalid();
        idexValid = 1'b0; idexAluOp = 4'd10; idexRs1Data = 32'd9; idexRs2Data = 32'd9;
        idexMemCtrl = 3'b111; idexWbCtrl = 2'b11; idexRd = 5'd9;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) $display("FAIL invalid_stall: got %b required 0", stall);
        else passed++;
        @(posedge clk); #1;
        check_idle_bubble("invalid_bubble");
    endtask

    task automatic test_muldiv();
        run_op("mulhu_max", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd10, 3'b000, 2'b01);
        run_op("mul_max", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd11, 3'b000, 2'b01);
        run_op("divu_100_7", 4'd12, 32'd100, 32'd7, 32'd0, 1'b0, 5'd12, 3'b000, 2'b01);
        run_op("remu_100_7", 4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 5'd13, 3'b000, 2'b01);
        run_op("divu_by0", 4'd12, 32'h12345678, 32'd0, 32'd0, 1'b0, 5'd14, 3'b000, 2'b01);
        run_op("remu_by0", 4'd13, 32'd123, 32'd0, 32'd0, 1'b0, 5'd15, 3'b000, 2'b01);
        run_op("divu_imm", 4'd12, 32'hFFFFFFFF, 32'd0, 32'd3, 1'b1, 5'd16, 3'b010, 2'b10);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_op("b2b_long", 4'($urandom_range(10, 13)), $urandom, $urandom_range(1, 32'hFFFF),
                   32'd0, 1'b0, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        run_op("b2b_short", 4'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'd0, 1'b0, 5'd1, 3'b001, 2'b01);
    endtask

    task automatic test_flush();
        idexValid = 1'b1; idexAluOp = 4'd12; idexRs1Data = 32'd1000; idexRs2Data = 32'd3;
        idexAluSrc = 1'b0; idexRd = 5'd20; idexMemCtrl = 3'b000; idexWbCtrl = 2'b01;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (dbgState !== 2'd1) $display("FAIL flush_busy_state: got %0d required 1", dbgState);
        else passed++;
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) $display("FAIL flush_cycle_stall: got %b required 1", stall);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b0;
        check_idle_bubble("flush_busy_bubble");
        run_op("add_after_flush", 4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd21, 3'b000, 2'b01);
        // A long op reaching DONE is still killed by flush.
        idexValid = 1'b1; idexAluOp = 4'd10; idexRs1Data = 32'd6; idexRs2Data = 32'd7;
        repeat (33) @(posedge clk);
        #1;
        total++;
        if (dbgState !== 2'd2) $display("FAIL flush_done_state: got %0d required 2", dbgState);
        else passed++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idexValid = 1'b0;
        check_idle_bubble("flush_done_bubble");
        idexValid = 1'b1; idexAluOp = 4'd0; idexRs1Data = 32'd1; idexRs2Data = 32'd1;
        idexWbCtrl = 2'b11; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idexValid = 1'b0;
        check_idle_bubble("flush_short_bubble");
    endtask

    task automatic test_reset_mid();
        run_op("add_before_rst", 4'd3, 32'h00F0, 32'h0F00, 32'd0, 1'b0, 5'd8, 3'b010, 2'b10);
        #2 rst = 1'b1;
        #1;
        check_idle_bubble("async_reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        idexValid = 1'b1; idexAluOp = 4'd10; idexRs1Data = 32'd3; idexRs2Data = 32'd5;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (dbgState !== 2'd1 || stall !== 1'b1)
            $display("FAIL mul_running: got state=%0d stall=%b required 1 1", dbgState, stall);
        else passed++;
        #2 rst = 1'b1;
        idexValid = 1'b0;
        #1;
        check_idle_bubble("reset_mid_mul");
        total++;
        if (stall !== 1'b0) $display("FAIL reset_mid_stall: got %b required 0", stall);
        else passed++;
        #1 rst = 1'b0;
        run_op("sltu_after_rst", 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd2, 3'b000, 2'b01);
        run_op("mul_after_rst", 4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 5'd3, 3'b000, 2'b01);
    endtask

    initial begin
        test_reset();
        test_short();
        test_invalid();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
